tick_interval_meter: RTL

- Receive-side counterpart to tick_generator: measures the clock-cycle interval between successive rising edges of a single-cycle or level pulse input.
- Used on the board to verify tick/debounce timing and to time external strobes.
- Reports each measured period with a one-cycle valid strobe, flags loss of pulses via timeout, and keeps a saturating pulse count.

---
 rtl/tick_interval_meter_pkg.sv | 13 +
 rtl/tick_interval_meter_pulse_edge_sync.sv | 27 ++
 rtl/tick_interval_meter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tick_interval_meter_pkg.sv
// Shared definitions for tick_interval_meter: FSM encoding and default widths.
package tick_interval_meter_pkg;

    localparam int COUNT_WIDTH_DEFAULT = 33;
    localparam int PULSE_COUNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } meter_state_e;

endpackage

// File: rtl/tick_interval_meter_pulse_edge_sync.sv
// Two-flop synchronizer plus history flop; o_rise is high for one cycle per rising edge.
module pulse_edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pulse,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_pulse;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tick_interval_meter.sv
// Measures clock cycles between rising edges of pulse_in; strobes period/timeout.
// Optional early/late period checking is built only when PERIOD_CHECK_EN is defined.
module tick_interval_meter
    import tick_interval_meter_pkg::*;
#(
    parameter int                     COUNT_WIDTH     = COUNT_WIDTH_DEFAULT,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT         = COUNT_WIDTH'(100_000_000),
    parameter logic [COUNT_WIDTH-1:0] EXPECTED_PERIOD = COUNT_WIDTH'(100_000),
    parameter logic [COUNT_WIDTH-1:0] TOLERANCE       = COUNT_WIDTH'(10)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         pulse_in,
    output logic [COUNT_WIDTH-1:0]       period,
    output logic                         period_valid,
    output logic                         timeout,
    output logic [PULSE_COUNT_WIDTH-1:0] pulse_count,
    output logic                         early,
    output logic                         late,
    output logic [1:0]                   state_dbg
);

    meter_state_e                   r_state;
    logic [COUNT_WIDTH-1:0]         r_count;
    logic [COUNT_WIDTH-1:0]         r_period;
    logic                           r_period_valid;
    logic                           r_timeout;
    logic [PULSE_COUNT_WIDTH-1:0]   r_pulse_count;
    logic                           w_rise;
    logic [COUNT_WIDTH-1:0]         w_period_next;

    pulse_edge_sync u_edge_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_pulse (pulse_in),
        .o_rise  (w_rise)
    );

    // The edge is seen one cycle after count last advanced, hence the +1.
    assign w_period_next = r_count + COUNT_WIDTH'(1);

`ifdef PERIOD_CHECK_EN
    logic r_early;
    logic r_late;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_pulse_count  <= '0;
`ifdef PERIOD_CHECK_EN
            r_early        <= 1'b0;
            r_late         <= 1'b0;
`endif
        end else begin
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
`ifdef PERIOD_CHECK_EN
            r_early        <= 1'b0;
            r_late         <= 1'b0;
`endif
            if (!enable) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_count <= '0;
                        r_state <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        r_count <= '0;
                        if (w_rise) r_state <= MEASURE;
                    end
                    MEASURE: begin
                        // An edge landing on the timeout cycle still counts as a period.
                        if (w_rise) begin
                            r_period       <= w_period_next;
                            r_period_valid <= 1'b1;
                            r_count        <= '0;
                            if (r_pulse_count != '1) r_pulse_count <= r_pulse_count + 1'b1;
`ifdef PERIOD_CHECK_EN
                            r_early <= (w_period_next < (EXPECTED_PERIOD - TOLERANCE));
                            r_late  <= (w_period_next > (EXPECTED_PERIOD + TOLERANCE));
`endif
                        end else if (r_count == TIMEOUT - COUNT_WIDTH'(1)) begin
                            r_timeout <= 1'b1;
                            r_count   <= '0;
                            r_state   <= WAIT_FIRST;
`ifdef PERIOD_CHECK_EN
                            r_late    <= 1'b1;
`endif
                        end else begin
                            r_count <= w_period_next;
                        end
                    end
                    default: begin
                        r_count <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign pulse_count  = r_pulse_count;
    assign state_dbg    = r_state;

`ifdef PERIOD_CHECK_EN
    assign early = r_early;
    assign late  = r_late;
`else
    assign early = 1'b0;
    assign late  = 1'b0;
`endif

endmodule
